// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side adapter for a synchronous FIFO's pop interface. It drains the
//   FIFO into a registered valid/ready stream through a 2-entry output buffer
//   and runs at full throughput. out_ready has no combinational path to
//   fifo_pop, because pop depends only on fifo_vld and the buffer occupancy
//   register. A flush request discards the buffered words, drains the FIFO
//   until it is empty, and then pulses flush_done.
//
//   Optional: define FIFO_RD_STATS_EN to add the word_cnt/stall_cnt
//   statistics counters and their ports.
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   fifo_vld, fifo_data    FIFO head valid / data (data valid while fifo_vld)
//   fifo_pop               pop request; consumed when fifo_pop && fifo_vld
//   out_valid, out_data    output stream (registered valid, buffer head data)
//   out_ready              downstream accept
//   flush, flush_done      flush request pulse / completion pulse
//   buf_cnt                output buffer occupancy (0..2)
//   word_cnt, stall_cnt    [FIFO_RD_STATS_EN] delivered words / stall cycles
module fifo_rd_stream #(
  parameter int DW   = 24,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fifo_vld,
  input  logic [DW-1:0]   fifo_data,
  output logic            fifo_pop,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
  input  logic            flush,
  output logic            flush_done,
  output logic [1:0]      buf_cnt
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNTW-1:0] word_cnt,
  output logic [CNTW-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {ST_STREAM, ST_FLUSH, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] buf_q [2];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          vld_q;
  logic          pop, cap, xfer;

  // out_valid is a register, so a transfer can only happen in STREAM.
  assign xfer = vld_q && out_ready;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    cap     = 1'b0;
    case (state_q)
      ST_STREAM: begin
        pop = fifo_vld && (cnt_q != 2'd2);
        if (flush) begin
          // The handshake and the pop in this cycle still complete, but the
          // popped word is never written and the buffer is emptied.
          state_d = ST_FLUSH;
          cnt_d   = 2'd0;
          wptr_d  = 1'b0;
          rptr_d  = 1'b0;
        end else begin
          cap = pop;
          if (cap)  wptr_d = ~wptr_q;
          if (xfer) rptr_d = ~rptr_q;
          case ({cap, xfer})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
          endcase
        end
      end
      ST_FLUSH: begin
        pop = fifo_vld;
        if (!fifo_vld) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_STREAM;
      default:  state_d = ST_STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_STREAM;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
      vld_q    <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      vld_q   <= (state_d == ST_STREAM) && (cnt_d != 2'd0);
      if (cap) buf_q[wptr_q] <= fifo_data;
    end
  end

  // Never pop during the reset cycle: the word would be lost.
  assign fifo_pop   = pop && rst_n;
  assign out_valid  = vld_q;
  assign out_data   = buf_q[rptr_q];
  assign flush_done = (state_q == ST_DONE);
  assign buf_cnt    = cnt_q;

`ifdef FIFO_RD_STATS_EN
  logic [CNTW-1:0] word_q, stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      stall_q <= '0;
    end else begin
      if (xfer && (word_q != '1))                       word_q  <= word_q + 1'b1;
      if (vld_q && !out_ready && (stall_q != '1))       stall_q <= stall_q + 1'b1;
    end
  end

  assign word_cnt  = word_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream. The bench owns an ideal FIFO, held as a queue,
// and a reference model that works at the transaction level. The model
// tracks the mode (stream/flush/done) and the words expected downstream.
// The stimulus process pushes expected words into a scoreboard queue.
// A negedge monitor compares the DUT outputs and pops the scoreboard on
// every handshake.
module tb_fifo_rd_stream;
`ifdef FIFO_RD_STATS_EN
  localparam int CNTW = 4;
`else
  localparam int CNTW = 16;
`endif
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_vld;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          flush;
  logic          flush_done;
  logic [1:0]    buf_cnt;
`ifdef FIFO_RD_STATS_EN
  logic [CNTW-1:0] word_cnt, stall_cnt;
`endif

  fifo_rd_stream #(.DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_vld(fifo_vld), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .flush_done(flush_done), .buf_cnt(buf_cnt)
`ifdef FIFO_RD_STATS_EN
    , .word_cnt(word_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state.
  typedef enum int {M_STREAM, M_FLUSH, M_DONE} mode_t;
  mode_t         mode;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] nxt;
  bit            rnd_data;
  bit            chk;
  int            total, bad;
  logic          e_pop, e_valid, e_done;
  int            e_cnt;
  int            m_word, m_stall;
  // Values sampled at the negedge of the previous cycle.
  logic          s_pop, s_vld, s_flush, s_rstn, s_rdy, s_valid;

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor and scoreboard.
  always @(negedge clk) begin
    if (chk) begin
      chk_eq("fifo_pop", {31'd0, fifo_pop}, {31'd0, e_pop});
      chk_eq("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
      chk_eq("buf_cnt", {30'd0, buf_cnt}, e_cnt);
      chk_eq("flush_done", {31'd0, flush_done}, {31'd0, e_done});
`ifdef FIFO_RD_STATS_EN
      chk_eq("word_cnt", {28'd0, word_cnt}, m_word);
      chk_eq("stall_cnt", {28'd0, stall_cnt}, m_stall);
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk_eq("unexpected_word", {8'd0, out_data}, 32'hFFFFFFFF);
        else chk_eq("out_data", {8'd0, out_data}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  // One clock cycle. The model first applies the previous cycle, then
  // drives new inputs and derives the expected outputs for this cycle.
  task automatic step(input bit rstn, input bit rdy, input bit fl, input int npush);
    int maxc;
    @(posedge clk);
    #1;
    if (s_pop && s_vld) void'(fifo_q.pop_front());
    if (!s_rstn) begin
      mode = M_STREAM;
      exp_q.delete();
      m_word = 0;
      m_stall = 0;
    end else begin
      maxc = (1 << CNTW) - 1;
      if (s_valid && s_rdy && m_word < maxc) m_word++;
      if (s_valid && !s_rdy && m_stall < maxc) m_stall++;
      case (mode)
        M_STREAM: begin
          if (s_flush) begin
            exp_q.delete();
            mode = M_FLUSH;
          end else if (s_pop && s_vld) exp_q.push_back(fifo_data);
        end
        M_FLUSH: if (!s_vld) mode = M_DONE;
        default: mode = M_STREAM;
      endcase
    end
    for (int k = 0; k < npush; k++) begin
      fifo_q.push_back(rnd_data ? DW'($urandom) : nxt);
      nxt = nxt + 1'b1;
    end
    rst_n     = rstn;
    out_ready = rdy;
    flush     = fl;
    fifo_vld  = (fifo_q.size() != 0);
    fifo_data = fifo_vld ? fifo_q[0] : '0;
    e_cnt     = exp_q.size();
    e_valid   = (mode == M_STREAM) && (e_cnt != 0);
    e_done    = (mode == M_DONE);
    if (!rstn)                  e_pop = 1'b0;
    else if (mode == M_STREAM)  e_pop = fifo_vld && (e_cnt < 2);
    else if (mode == M_FLUSH)   e_pop = fifo_vld;
    else                        e_pop = 1'b0;
    chk = 1'b1;
    @(negedge clk);
    s_pop   = fifo_pop;
    s_vld   = fifo_vld;
    s_flush = flush && (mode == M_STREAM);
    s_rstn  = rst_n;
    s_rdy   = out_ready;
    s_valid = e_valid;
  endtask

  initial begin
    total = 0; bad = 0; chk = 1'b0; rnd_data = 1'b0; nxt = 24'h000001;
    mode = M_STREAM; m_word = 0; m_stall = 0;
    e_pop = 0; e_valid = 0; e_done = 0; e_cnt = 0;
    s_pop = 0; s_vld = 0; s_flush = 0; s_rstn = 0; s_rdy = 0; s_valid = 0;
    rst_n = 1'b0; out_ready = 1'b1; flush = 1'b0; fifo_vld = 1'b0; fifo_data = '0;
    @(posedge clk);

    // T1: reset held with the FIFO non-empty (words 1..8 queued).
    step(0, 1, 0, 8);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk_eq("reset_out_data", {8'd0, out_data}, 32'd0);

    // T2: stream words 1..8 back to back.
    repeat (12) step(1, 1, 0, 0);

    // T3: backpressure with 6 words, then release.
    step(1, 0, 0, 6);
    repeat (6) step(1, 0, 0, 0);
    repeat (10) step(1, 1, 0, 0);

    // T4: flush with a full buffer and 5 words left in the FIFO.
    step(1, 0, 0, 7);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    repeat (8) step(1, 0, 0, 0);
    nxt = 24'hABCDEF;
    step(1, 1, 0, 1);
    repeat (4) step(1, 1, 0, 0);

    // T5: reset with a full buffer, then reset during FLUSH.
    step(1, 0, 0, 6);
    repeat (4) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (10) step(1, 1, 0, 0);
    step(1, 1, 0, 8);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    repeat (12) step(1, 1, 0, 0);

    // Randomized traffic with occasional flush and reset.
    rnd_data = 1'b1;
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 149) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0,
           (fifo_q.size() < 10 && $urandom_range(0, 2) != 0) ? int'($urandom_range(1, 2)) : 0);

    // Drain, then check that everything was delivered.
    repeat (20) step(1, 1, 0, 0);
    chk_eq("drain_scoreboard", exp_q.size(), 0);
    chk_eq("drain_fifo", fifo_q.size(), 0);

    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
